// File: rtl/mempool_pkg.sv
`default_nettype none
//==============================================================================
// Module      : mempool_pkg
// Description : Shared L2 memory constants, the L2 bank controller state type
//               and a small saturating-counter helper.
//               Optional macro L2_ZERO_INIT_EN adds the INIT (zero sweep) state.
// Revision    : 1.0 - initial release
//==============================================================================
package mempool_pkg;

    // L2 memory geometry shared by the memory-side blocks
    localparam int unsigned c_axi_data_width     = 512;
    localparam logic [31:0] c_l2_base_addr       = 32'h8000_0000;
    localparam logic [31:0] c_l2_size            = 32'h0010_0000;
    localparam int unsigned c_l2_be_width        = c_axi_data_width / 8;
    localparam int unsigned c_l2_byte_offset     = $clog2(c_l2_be_width);
    localparam int unsigned c_num_l2_banks       = 4;
    localparam int unsigned c_l2_bank_addr_width =
        $clog2(c_l2_size / c_l2_be_width / c_num_l2_banks);
    localparam int unsigned c_sram_latency       = 1;

    // Bank controller states; INIT exists only when the zero sweep is built in
`ifdef L2_ZERO_INIT_EN
    typedef enum logic [0:0] {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } l2_state_e;
`else
    typedef enum logic [0:0] {
        S_RUN  = 1'b0
    } l2_state_e;
`endif

    // 16-bit increment that sticks at all-ones
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage : mempool_pkg
`default_nettype wire

// File: rtl/l2_resp_pipe.sv
`default_nettype none
//==============================================================================
// Module      : l2_resp_pipe
// Description : Response pipeline for the L2 bank controller. A shift register
//               of DEPTH entries tracks {valid, bank idx, we, oor} alongside
//               the SRAM access; at the last stage the read data is picked
//               from the addressed bank (zero for writes / out-of-range) and
//               optionally registered once more (RESP_CUT).
// Revision    : 1.0 - initial release
//==============================================================================
module l2_resp_pipe #(
    parameter int unsigned DATA_WIDTH = 512,
    parameter int unsigned NUM_BANKS  = 4,
    parameter int unsigned IDX_W      = 2,
    parameter int unsigned DEPTH      = 1,
    parameter int unsigned RESP_CUT   = 1
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 i_valid,
    input  logic [IDX_W-1:0]                     i_idx,
    input  logic                                 i_we,
    input  logic                                 i_oor,
    input  logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] i_bank_rdata,
    output logic                                 o_rvalid,
    output logic [DATA_WIDTH-1:0]                o_rdata
);

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
        logic             we;
        logic             oor;
    } pipe_t;

    pipe_t                 r_pipe [DEPTH];
    pipe_t                 w_tail;
    logic                  w_rvalid;
    logic [DATA_WIDTH-1:0] w_rdata;

    // Shift the request tag along with the SRAM access; reset drops in-flight tags
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= '{valid: i_valid, idx: i_idx, we: i_we, oor: i_oor};
            for (int i = 1; i < int'(DEPTH); i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    // Last stage: bank data is valid now, pick it unless the access returns no data
    always_comb begin
        w_tail   = r_pipe[DEPTH-1];
        w_rvalid = w_tail.valid;
        w_rdata  = '0;
        if (w_tail.valid && !w_tail.we && !w_tail.oor) begin
            w_rdata = i_bank_rdata[w_tail.idx];
        end
    end

    if (RESP_CUT != 0) begin : g_resp_cut
        // Extra output register to break the bank-rdata to rdata_o path
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                o_rvalid <= 1'b0;
                o_rdata  <= '0;
            end else begin
                o_rvalid <= w_rvalid;
                o_rdata  <= w_rdata;
            end
        end
    end else begin : g_resp_comb
        assign o_rvalid = w_rvalid;
        assign o_rdata  = w_rdata;
    end

endmodule : l2_resp_pipe
`default_nettype wire

// File: rtl/l2_bank_ctrl.sv
`default_nettype none
//==============================================================================
// Module      : l2_bank_ctrl
// Description : Memory-side L2 stage. Takes one wide req/gnt request stream,
//               word-interleaves it over NUM_L2_BANKS SRAM banks and returns
//               in-order responses after SRAM_LATENCY + RESP_CUT cycles.
//               Out-of-range accesses touch no bank, return zero data and are
//               flagged (sticky flag + saturating counter).
//               Optional macro L2_ZERO_INIT_EN: after reset all banks are
//               swept with zero writes before requests are accepted.
// Revision    : 1.0 - initial release
//==============================================================================
module l2_bank_ctrl
    import mempool_pkg::*;
#(
    parameter int unsigned             DATA_WIDTH   = c_axi_data_width,
    parameter int unsigned             ADDR_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0]   L2_BASE_ADDR = c_l2_base_addr,
    parameter logic [ADDR_WIDTH-1:0]   L2_SIZE      = c_l2_size,
    parameter int unsigned             NUM_L2_BANKS = c_num_l2_banks,
    parameter int unsigned             SRAM_LATENCY = c_sram_latency,
    parameter int unsigned             RESP_CUT     = 1,
    localparam int unsigned            BE_WIDTH     = DATA_WIDTH / 8,
    localparam int unsigned            BANK_ADDR_WIDTH =
        $clog2(L2_SIZE / BE_WIDTH / NUM_L2_BANKS)
) (
    input  logic                                       clk_i,
    input  logic                                       rst_ni,
    input  logic                                       req_i,
    output logic                                       gnt_o,
    input  logic [ADDR_WIDTH-1:0]                      addr_i,
    input  logic                                       we_i,
    input  logic [DATA_WIDTH-1:0]                      wdata_i,
    input  logic [BE_WIDTH-1:0]                        strb_i,
    output logic                                       rvalid_o,
    output logic [DATA_WIDTH-1:0]                      rdata_o,
    output logic [NUM_L2_BANKS-1:0]                    bank_req_o,
    output logic [NUM_L2_BANKS-1:0]                    bank_we_o,
    output logic [NUM_L2_BANKS-1:0][BANK_ADDR_WIDTH-1:0] bank_addr_o,
    output logic [NUM_L2_BANKS-1:0][DATA_WIDTH-1:0]    bank_wdata_o,
    output logic [NUM_L2_BANKS-1:0][BE_WIDTH-1:0]      bank_be_o,
    input  logic [NUM_L2_BANKS-1:0][DATA_WIDTH-1:0]    bank_rdata_i,
    output logic                                       oor_err_o,
    output logic [15:0]                                oor_cnt_o,
    output logic                                       init_done_o
);

    localparam int unsigned BYTE_OFF      = $clog2(BE_WIDTH);
    localparam int unsigned BANK_SEL_BITS = $clog2(NUM_L2_BANKS);
    localparam int unsigned IDX_W         = (BANK_SEL_BITS == 0) ? 1 : BANK_SEL_BITS;

    l2_state_e                  r_state;
    l2_state_e                  w_state_next;
    logic                       r_init_done;
    logic                       r_oor_err;
    logic [15:0]                r_oor_cnt;
    logic                       w_gnt;
    logic [ADDR_WIDTH-1:0]      w_offset;
    logic                       w_oor;
    logic [IDX_W-1:0]           w_bank_idx;
    logic [BANK_ADDR_WIDTH-1:0] w_bank_addr;

`ifdef L2_ZERO_INIT_EN
    localparam logic [BANK_ADDR_WIDTH-1:0] INIT_LAST = '1;
    logic [BANK_ADDR_WIDTH-1:0] r_init_cnt;
`endif

    // Address decode: offset from base, word index, interleaved bank and row
    always_comb begin
        w_offset    = addr_i - L2_BASE_ADDR;
        // Comparing the offset avoids overflow of base+size at the top of the map
        w_oor       = (addr_i < L2_BASE_ADDR) || (w_offset >= L2_SIZE);
        w_bank_addr = w_offset[BYTE_OFF+BANK_SEL_BITS +: BANK_ADDR_WIDTH];
        w_bank_idx  = (NUM_L2_BANKS > 1) ? w_offset[BYTE_OFF +: IDX_W] : '0;
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
`ifdef L2_ZERO_INIT_EN
            r_state <= S_INIT;
`else
            r_state <= S_RUN;
`endif
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and grant; grant waits for init_done so it is low out of reset
    always_comb begin
        w_state_next = r_state;
        w_gnt        = 1'b0;
        case (r_state)
`ifdef L2_ZERO_INIT_EN
            S_INIT: begin
                if (r_init_cnt == INIT_LAST) begin
                    w_state_next = S_RUN;
                end
            end
`endif
            S_RUN: begin
                w_gnt = req_i & r_init_done;
            end
            default: begin
                w_state_next = r_state;
            end
        endcase
    end

`ifdef L2_ZERO_INIT_EN
    // Zero-sweep row counter, advancing once per INIT cycle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_init_cnt <= '0;
        end else if (r_state == S_INIT) begin
            r_init_cnt <= r_init_cnt + 1'b1;
        end
    end
`endif

    // Ready flag rises on the same edge the FSM settles in RUN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_init_done <= 1'b0;
        end else begin
            r_init_done <= (w_state_next == S_RUN);
        end
    end

    // Out-of-range bookkeeping on granted requests only
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_oor_err <= 1'b0;
            r_oor_cnt <= '0;
        end else if (w_gnt && w_oor) begin
            r_oor_err <= 1'b1;
            r_oor_cnt <= sat_inc16(r_oor_cnt);
        end
    end

    // Bank request routing: sweep writes in INIT, one selected bank in RUN
    always_comb begin
        bank_req_o   = '0;
        bank_we_o    = '0;
        bank_addr_o  = '0;
        bank_wdata_o = '0;
        bank_be_o    = '0;
`ifdef L2_ZERO_INIT_EN
        if (r_state == S_INIT) begin
            bank_req_o = '1;
            bank_we_o  = '1;
            bank_be_o  = '1;
            for (int b = 0; b < int'(NUM_L2_BANKS); b++) begin
                bank_addr_o[b] = r_init_cnt;
            end
        end
`endif
        if (w_gnt && !w_oor) begin
            for (int b = 0; b < int'(NUM_L2_BANKS); b++) begin
                if (IDX_W'(b) == w_bank_idx) begin
                    bank_req_o[b]   = 1'b1;
                    bank_we_o[b]    = we_i;
                    bank_addr_o[b]  = w_bank_addr;
                    bank_wdata_o[b] = wdata_i;
                    bank_be_o[b]    = strb_i;
                end
            end
        end
    end

    l2_resp_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_BANKS  (NUM_L2_BANKS),
        .IDX_W      (IDX_W),
        .DEPTH      (SRAM_LATENCY),
        .RESP_CUT   (RESP_CUT)
    ) u_resp_pipe (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .i_valid      (w_gnt),
        .i_idx        (w_bank_idx),
        .i_we         (we_i),
        .i_oor        (w_oor),
        .i_bank_rdata (bank_rdata_i),
        .o_rvalid     (rvalid_o),
        .o_rdata      (rdata_o)
    );

    assign gnt_o       = w_gnt;
    assign oor_err_o   = r_oor_err;
    assign oor_cnt_o   = r_oor_cnt;
    assign init_done_o = r_init_done;

endmodule : l2_bank_ctrl
`default_nettype wire

// File: tb/tb_l2_bank_ctrl.sv
`default_nettype none
//==============================================================================
// Module      : tb_l2_bank_ctrl
// Description : Bench for l2_bank_ctrl with a behavioural 1-cycle SRAM per
//               bank. Stimulus pushes expected responses into a queue; a
//               monitor pops and compares whenever rvalid_o is seen.
//               Build with L2_ZERO_INIT_EN to exercise the zero sweep.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_l2_bank_ctrl;

    localparam int          DW   = 512;
    localparam int          BEW  = DW / 8;
    localparam int          NB   = 4;
    localparam int          BAW  = 12;
    localparam int          LAT  = 2;
    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam logic [31:0] SIZE = 32'h0010_0000;
`ifdef L2_ZERO_INIT_EN
    localparam int          INIT_CYC = 1 << BAW;
`else
    localparam int          INIT_CYC = 1;
`endif

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    logic                     clk   = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     req   = 1'b0;
    logic                     we    = 1'b0;
    logic [31:0]              addr  = '0;
    logic [DW-1:0]            wdata = '0;
    logic [BEW-1:0]           strb  = '0;
    logic                     gnt_o;
    logic                     rvalid_o;
    logic [DW-1:0]            rdata_o;
    logic [NB-1:0]            bank_req_o;
    logic [NB-1:0]            bank_we_o;
    logic [NB-1:0][BAW-1:0]   bank_addr_o;
    logic [NB-1:0][DW-1:0]    bank_wdata_o;
    logic [NB-1:0][BEW-1:0]   bank_be_o;
    logic [NB-1:0][DW-1:0]    bank_rdata = '0;
    logic                     oor_err_o;
    logic [15:0]              oor_cnt_o;
    logic                     init_done_o;

    int            cyc      = 0;
    int            n_checks = 0;
    int            n_pass   = 0;
    exp_t          exp_q[$];
    exp_t          mon_e;
    logic [DW-1:0] mem [int];
    logic [DW-1:0] sram_tmp;
    int            sram_key;

    l2_bank_ctrl dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_i        (req),
        .gnt_o        (gnt_o),
        .addr_i       (addr),
        .we_i         (we),
        .wdata_i      (wdata),
        .strb_i       (strb),
        .rvalid_o     (rvalid_o),
        .rdata_o      (rdata_o),
        .bank_req_o   (bank_req_o),
        .bank_we_o    (bank_we_o),
        .bank_addr_o  (bank_addr_o),
        .bank_wdata_o (bank_wdata_o),
        .bank_be_o    (bank_be_o),
        .bank_rdata_i (bank_rdata),
        .oor_err_o    (oor_err_o),
        .oor_cnt_o    (oor_cnt_o),
        .init_done_o  (init_done_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural SRAM banks: write with byte enables, registered read
    always @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (bank_req_o[b]) begin
                sram_key = b * (1 << BAW) + int'(bank_addr_o[b]);
                sram_tmp = mem.exists(sram_key) ? mem[sram_key] : '0;
                if (bank_we_o[b]) begin
                    for (int i = 0; i < BEW; i++) begin
                        if (bank_be_o[b][i]) sram_tmp[8*i +: 8] = bank_wdata_o[b][8*i +: 8];
                    end
                    mem[sram_key] = sram_tmp;
                end else begin
                    bank_rdata[b] <= sram_tmp;
                end
            end
        end
    end

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [31:0] waddr(input int w);
        return BASE + 32'(w * BEW);
    endfunction

    function automatic logic [DW-1:0] pat(input int w);
        return {16{32'hC0DE_0000 + 32'(w)}};
    endfunction

    // Monitor: every response must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rvalid_o) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rvalid", 1'b1, 1'b0);
            end else begin
                mon_e = exp_q.pop_front();
                check("rdata", rdata_o, mon_e.data);
                check("rvalid_cycle", cyc, mon_e.cyc);
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic w, input logic [DW-1:0] d,
                        input logic [BEW-1:0] s, input logic [NB-1:0] exp_breq,
                        input logic [DW-1:0] exp_rdata);
        @(posedge clk);
        #1;
        req = 1'b1; addr = a; we = w; wdata = d; strb = s;
        #1;
        check("gnt", gnt_o, 1'b1);
        check("bank_req", bank_req_o, exp_breq);
        exp_q.push_back('{exp_rdata, cyc + LAT});
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        req = 1'b0; we = 1'b0;
    endtask

    task automatic check_reset_values();
        check("rst_gnt", gnt_o, 1'b0);
        check("rst_rvalid", rvalid_o, 1'b0);
        check("rst_rdata", rdata_o, '0);
        check("rst_bank_req", bank_req_o, '0);
        check("rst_oor_err", oor_err_o, 1'b0);
        check("rst_oor_cnt", oor_cnt_o, '0);
        check("rst_init_done", init_done_o, 1'b0);
    endtask

    // Release reset, hold a request up during the wait and expect it ignored
    task automatic release_and_wait();
        int  n;
        logic gnt_seen;
        n = 0;
        gnt_seen = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        req = 1'b1; we = 1'b0; addr = waddr(0);
        while (!init_done_o && n < INIT_CYC + 16) begin
            @(posedge clk);
            #1;
            n++;
            if (!init_done_o && gnt_o) gnt_seen = 1'b1;
        end
        req = 1'b0;
        check("init_done", init_done_o, 1'b1);
        check("init_cycles", n, INIT_CYC);
        check("gnt_low_before_ready", gnt_seen, 1'b0);
    endtask

    initial begin
        #1;
        check_reset_values();
        repeat (3) @(posedge clk);
        release_and_wait();

`ifdef L2_ZERO_INIT_EN
        // Swept memory reads back as zero
        send(waddr(5), 1'b0, '0, '0, 4'b0010, '0);
        send(waddr(BAW), 1'b0, '0, '0, 4'b0001, '0);
        idle();
`endif

        // Write then immediately read word 1 (bank 1, row 0)
        send(BASE + 32'h40, 1'b1, {BEW{8'hA5}}, '1, 4'b0010, '0);
        check("w_bank_addr1", bank_addr_o[1], '0);
        check("w_bank_we1", bank_we_o, 4'b0010);
        check("w_bank_wdata1", bank_wdata_o[1], {BEW{8'hA5}});
        send(BASE + 32'h40, 1'b0, '0, '0, 4'b0010, {BEW{8'hA5}});
        check("r_bank_we", bank_we_o, 4'b0000);
        idle();

        // Fill words 0..7, then read them back-to-back
        for (int i = 0; i < 8; i++) send(waddr(i), 1'b1, pat(i), '1, NB'(1 << (i % NB)), '0);
        for (int i = 0; i < 8; i++) send(waddr(i), 1'b0, '0, '0, NB'(1 << (i % NB)), pat(i));
        idle();

        // Out-of-range below the base and exactly at the end of the map
        send(32'h7FFF_FFC0, 1'b0, '0, '0, 4'b0000, '0);
        idle();
        check("oor_err_1", oor_err_o, 1'b1);
        check("oor_cnt_1", oor_cnt_o, 16'd1);
        send(BASE + SIZE, 1'b1, '1, '1, 4'b0000, '0);
        idle();
        check("oor_cnt_2", oor_cnt_o, 16'd2);

        // Last word of the map: bank 3, top row
        send(BASE + SIZE - 32'(BEW), 1'b1, pat(99), '1, 4'b1000, '0);
        check("last_bank_addr", bank_addr_o[3], {BAW{1'b1}});
        send(BASE + SIZE - 32'(BEW), 1'b0, '0, '0, 4'b1000, pat(99));
        idle();

        // Partial-strobe write over an all-ones word
        send(waddr(10), 1'b1, '1, '1, 4'b0100, '0);
        send(waddr(10), 1'b1, {{(DW-32){1'b0}}, 32'hDEAD_BEEF}, BEW'(4'hF), 4'b0100, '0);
        check("strb_be", bank_be_o[2], BEW'(4'hF));
        send(waddr(10), 1'b0, '0, '0, 4'b0100, {{(DW-32){1'b1}}, 32'hDEAD_BEEF});
        idle();

        // Reset with reads outstanding: none of them may come back
        repeat (LAT + 2) @(posedge clk);
        check("drained_before_reset", exp_q.size(), 0);
        @(posedge clk);
        #1;
        req = 1'b1; we = 1'b0; addr = waddr(0);
        @(posedge clk);
        #1;
        addr = waddr(1);
        #2;
        rst_n = 1'b0;
        req = 1'b0;
        #1;
        check_reset_values();
        repeat (3) @(posedge clk);
        release_and_wait();
        check("post_rst_oor_err", oor_err_o, 1'b0);
        repeat (LAT + 4) @(posedge clk);

        // Pipeline works again after reset
`ifdef L2_ZERO_INIT_EN
        send(waddr(3), 1'b0, '0, '0, 4'b1000, '0);
`else
        send(waddr(3), 1'b0, '0, '0, 4'b1000, pat(3));
`endif
        idle();
        repeat (LAT + 3) @(posedge clk);
        check("all_responses_seen", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, got cycle %0d expected completion", cyc);
        $fatal(1);
    end

endmodule : tb_l2_bank_ctrl
`default_nettype wire
